// File: rtl/mips_alu_pkg.sv
// Shared MIPS ALU package: ALU function codes, mul/div op codes,
// mul/div FSM states and the clock/reset control bundle.
package mips_alu_pkg;

  // ALU function select for the integer datapath
  typedef enum logic [3:0] {
    FUNC_ADD, FUNC_SUB, FUNC_AND, FUNC_OR, FUNC_XOR, FUNC_NOR,
    FUNC_SLT, FUNC_SLTU, FUNC_SLL, FUNC_SRL, FUNC_SRA, FUNC_LUI
  } func_e;

  localparam int OP_W = 4;

  // Mul/div unit operations
  typedef enum logic [OP_W-1:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8,
    OP_MSUB  = 4'd9,
    OP_MSUBU = 4'd10
  } op_e;

  // Mul/div sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_e;

  // Data_Control bundle: clock plus async active-high reset
  typedef struct packed {
    logic clock;
    logic reset;
  } data_control_t;

  // Signed flavours of the multiply/divide/accumulate ops
  function automatic logic op_is_signed(input op_e o);
    return (o == OP_MULT) || (o == OP_DIV) || (o == OP_MADD) || (o == OP_MSUB);
  endfunction

endpackage

// File: rtl/mips_alu_divstep.sv
// One radix-2 restoring divide step: shifts the next dividend bit into the
// partial remainder and subtracts the divisor if it fits.
module mips_alu_divstep
  import mips_alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem,
  input  logic              in_bit,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_next,
  output logic              q_bit
);
  logic [DATA_W:0] partial;
  logic [DATA_W:0] diff;

  // rem < divisor on entry, so partial < 2*divisor and the result fits DATA_W
  assign partial  = {rem, in_bit};
  assign diff     = partial - {1'b0, divisor};
  assign q_bit    = ~diff[DATA_W];
  assign rem_next = q_bit ? diff[DATA_W-1:0] : partial[DATA_W-1:0];
endmodule

// File: rtl/mips_alu_muldiv.sv
// MIPS HI/LO multiply/divide unit. Multi-cycle multiply (fixed latency) and
// restoring divide with a final sign-fix cycle.
// Optional multiply-accumulate (MADD/MADDU/MSUB/MSUBU) under macro
// MIPS_ALU_MULDIV_MACC_EN; without it those ops are ignored like NONE.
module mips_alu_muldiv
  import mips_alu_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int MUL_CYCLES = 2
) (
  input  data_control_t     ctrl,
  input  logic              start,
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  input  logic              kill,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              busy,
  output logic              done
);
  localparam int CNT_W = $clog2(DATA_W);

  logic clk, rst;
  assign clk = ctrl.clock;
  assign rst = ctrl.reset;

  state_e state, state_nxt;
  logic [CNT_W-1:0] cnt;
  op_e  op_in;
  logic op_mul, op_div, op_mt, op_sgn, accept, last_mul, last_div;

  logic [2*DATA_W-1:0] a_ext, b_ext, prod, prod_q, mul_res;
  logic [DATA_W-1:0]   quo, rem, dvs, dvd_raw, rem_nxt, q_fix, r_fix;
  logic                q_bit, neg_q, neg_r, dvs_zero;

  assign op_in    = op_e'(op);
  assign op_sgn   = op_is_signed(op_in);
  assign busy     = (state != ST_IDLE);
  assign accept   = start & ~busy & ~kill & (op_mul | op_div | op_mt);
  assign last_mul = (cnt == CNT_W'(MUL_CYCLES - 1));
  assign last_div = (cnt == CNT_W'(DATA_W - 1));

  // Classify the requested op; disabled accumulate ops fall out as NONE
  always_comb begin
    op_mul = 1'b0;
    op_div = 1'b0;
    op_mt  = 1'b0;
    case (op_in)
      OP_MULT, OP_MULTU: op_mul = 1'b1;
`ifdef MIPS_ALU_MULDIV_MACC_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: op_mul = 1'b1;
`endif
      OP_DIV, OP_DIVU:   op_div = 1'b1;
      OP_MTHI, OP_MTLO:  op_mt  = 1'b1;
      default: ;
    endcase
  end

  // Full-width product; truncation to 2*DATA_W gives the wrapped result
  assign a_ext = {{DATA_W{op_sgn & data1[DATA_W-1]}}, data1};
  assign b_ext = {{DATA_W{op_sgn & data2[DATA_W-1]}}, data2};
  assign prod  = a_ext * b_ext;

`ifdef MIPS_ALU_MULDIV_MACC_EN
  logic [1:0] macc_q;  // 0: plain, 1: accumulate add, 2: accumulate subtract

  // Remember accumulate flavour for the write-back at the end of MUL
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      macc_q <= 2'd0;
    else if (accept && op_mul)
      macc_q <= (op_in == OP_MADD || op_in == OP_MADDU) ? 2'd1 :
                (op_in == OP_MSUB || op_in == OP_MSUBU) ? 2'd2 : 2'd0;
  end

  // Accumulate against the current HI/LO pair
  always_comb begin
    mul_res = prod_q;
    case (macc_q)
      2'd1:    mul_res = {hi, lo} + prod_q;
      2'd2:    mul_res = {hi, lo} - prod_q;
      default: mul_res = prod_q;
    endcase
  end
`else
  assign mul_res = prod_q;
`endif

  mips_alu_divstep #(.DATA_W(DATA_W)) u_divstep (
    .rem      (rem),
    .in_bit   (quo[DATA_W-1]),
    .divisor  (dvs),
    .rem_next (rem_nxt),
    .q_bit    (q_bit)
  );

  // Quotient truncates toward zero; remainder takes the dividend's sign
  assign q_fix = dvs_zero ? '1      : (neg_q ? -quo : quo);
  assign r_fix = dvs_zero ? dvd_raw : (neg_r ? -rem : rem);

  // Sequencer state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Sequencer next state; kill always drops back to IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept && op_mul)      state_nxt = ST_MUL;
               else if (accept && op_div) state_nxt = ST_DIV;
      ST_MUL:  if (kill || last_mul)      state_nxt = ST_IDLE;
      ST_DIV:  if (kill)                  state_nxt = ST_IDLE;
               else if (last_div)         state_nxt = ST_FIX;
      ST_FIX:                             state_nxt = ST_IDLE;
      default:                            state_nxt = ST_IDLE;
    endcase
  end

  // Cycle/iteration counter for MUL latency and divide steps
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    cnt <= '0;
    else if (kill || accept)                    cnt <= '0;
    else if (state == ST_MUL || state == ST_DIV) cnt <= cnt + CNT_W'(1);
    else                                        cnt <= '0;
  end

  // Operand capture at accept, one restoring step per DIV cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q   <= '0;
      quo      <= '0;
      rem      <= '0;
      dvs      <= '0;
      dvd_raw  <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dvs_zero <= 1'b0;
    end else if (accept) begin
      prod_q   <= prod;
      quo      <= (op_sgn && data1[DATA_W-1]) ? -data1 : data1;
      dvs      <= (op_sgn && data2[DATA_W-1]) ? -data2 : data2;
      rem      <= '0;
      dvd_raw  <= data1;
      neg_q    <= op_sgn & (data1[DATA_W-1] ^ data2[DATA_W-1]);
      neg_r    <= op_sgn & data1[DATA_W-1];
      dvs_zero <= (data2 == '0);
    end else if (state == ST_DIV) begin
      rem <= rem_nxt;
      quo <= {quo[DATA_W-2:0], q_bit};
    end
  end

  // Architectural HI/LO and the done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept && op_in == OP_MTHI) hi <= data1;
      if (accept && op_in == OP_MTLO) lo <= data1;
      if (!kill && state == ST_MUL && last_mul) begin
        {hi, lo} <= mul_res;
        done     <= 1'b1;
      end
      if (!kill && state == ST_FIX) begin
        hi   <= r_fix;
        lo   <= q_fix;
        done <= 1'b1;
      end
    end
  end
endmodule

// File: doc/mips_alu_muldiv.md
MIPS_ALU_MULDIV -- requirements
Module: mips_alu_muldiv

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/HI/LO width (even, >=8).
REQ-002 SHALL have parameter MUL_CYCLES, default 2, multiply latency in cycles (1..4).
REQ-003 SHALL have port ctrl, input, Data_Control bundle: one clock (Data_Control_Clock); reset (Data_Control_Reset), asynchronous, active-high.
REQ-004 SHALL have port start, input, 1: request; accepted only when busy==0.
REQ-005 SHALL have port op, input, 4: operation: NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO, MADD, MADDU, MSUB, MSUBU.
REQ-006 SHALL have ports data1 and data2, input, DATA_W: rs and rt operands, sampled at accept.
REQ-007 SHALL have port kill, input, 1: pipeline flush; aborts any in-flight operation.
REQ-008 SHALL have ports hi and lo, output, DATA_W: architectural HI/LO registers.
REQ-009 SHALL have port busy, output, 1: operation in flight; upstream stalls mfhi/mflo/start.
REQ-010 SHALL have port done, output, 1: one-cycle pulse in the cycle hi/lo first show a new mul/div result.

Function
REQ-011 SHALL accept at a rising edge where start==1, busy==0, kill==0, op!=NONE; start while busy SHALL be ignored.
REQ-012 MTHI/MTLO SHALL write hi/lo (data1) at the accept edge, no busy, no done.
REQ-013 FSM states IDLE, MUL, DIV, FIX; IDLE->MUL on multiply/accumulate accept, IDLE->DIV on divide accept, MUL->IDLE after MUL_CYCLES, DIV->FIX after DATA_W iterations, FIX->IDLE after 1 cycle.
REQ-014 busy SHALL be 1 in every state except IDLE.
REQ-015 MULT/MULTU SHALL write {hi,lo} = full 2*DATA_W-bit signed/unsigned product at the edge leaving MUL; done high for the following cycle.
REQ-016 DIV/DIVU SHALL use radix-2 restoring iteration on magnitudes, one quotient bit per cycle, sign fix in FIX; lo=quotient truncated toward zero, hi=remainder with dividend's sign; total busy DATA_W+1 cycles.
REQ-017 Divide by zero SHALL give lo = all ones, hi = data1, done asserted normally.
REQ-018 Signed DIV of most-negative by -1 SHALL give lo = most-negative, hi = 0.
REQ-019 kill SHALL return FSM to IDLE at the next edge, leave hi/lo unchanged, suppress done; kill with start in the same cycle SHALL not accept.
REQ-020 All arithmetic SHALL wrap modulo 2^(2*DATA_W); no overflow flag.

Reset
REQ-021 Reset SHALL asynchronously force hi=0, lo=0, busy=0, done=0, FSM IDLE, iteration counter 0, including mid-operation.
REQ-022 First accept SHALL be possible at the first edge after reset deassertion.

Configuration
REQ-023 With macro MIPS_ALU_MULDIV_MACC_EN defined, MADD/MADDU SHALL write {hi,lo} += product and MSUB/MSUBU {hi,lo} -= product, same latency as MULT.
REQ-024 Without MIPS_ALU_MULDIV_MACC_EN, MADD/MADDU/MSUB/MSUBU SHALL be treated as NONE (not accepted, no state change) and accumulate logic SHALL not be synthesized.

Structure
REQ-025 Op encodings, FSM state encodings and op-width constant SHALL live in the shared Mips_Alu package, alongside existing Func definitions.
REQ-026 Divider datapath SHALL be one sub-module, mips_alu_divstep (one restoring step: partial remainder, divisor -> next remainder, quotient bit); the top holds FSM, multiplier delay line and HI/LO.

Verification
REQ-027 MULT 0xFFFFFFFF x 0x00000002 (DATA_W=32, MUL_CYCLES=2) -> busy 2 cycles, hi=0xFFFFFFFF, lo=0xFFFFFFFE, done one cycle.
REQ-028 DIVU 100 / 7 -> busy 33 cycles, lo=14, hi=2; DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-029 DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; DIVU 5 / 0 -> lo=0xFFFFFFFF, hi=5.
REQ-030 kill asserted on cycle 10 of a DIV -> busy low next cycle, hi/lo keep prior values, no done pulse.
REQ-031 Reset asserted mid-MUL -> hi=lo=0, busy=0 immediately; start during busy -> ignored, results match first op only.
REQ-032 With MIPS_ALU_MULDIV_MACC_EN, hi/lo=0/10 then MADDU 3 x 4 -> lo=22, hi=0; without the macro, same stimulus -> busy stays 0, lo=10.
